stream_align: RTL and testbench

STREAM_ALIGN -- requirements
Module: stream_align

---
 rtl/stream_align.sv | 112 +++++++++++
 tb/tb_stream_align.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_align.sv
// Two-lane stream aligner: each lane is buffered in its own FIFO and the Nth sample
// of lane A is emitted together with the Nth sample of lane B as soon as both exist.
module stream_align #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic [DATA_WIDTH-1:0]           din_a,
  input  logic                            din_a_valid,
  input  logic [DATA_WIDTH-1:0]           din_b,
  input  logic                            din_b_valid,
  output logic [DATA_WIDTH-1:0]           dout_a,
  output logic [DATA_WIDTH-1:0]           dout_b,
  output logic                            dout_valid,
  output logic [$clog2(FIFO_DEPTH)+1:0]   skew,
  output logic                            ovf_a,
  output logic                            ovf_b
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = AW + 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_a_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_b_q [FIFO_DEPTH];

  logic [AW-1:0]         wr_a_q, rd_a_q, wr_b_q, rd_b_q;
  logic [CW-1:0]         cnt_a_q, cnt_b_q, cnt_a_d, cnt_b_d;
  logic [SW-1:0]         skew_q, skew_d;
  logic [DATA_WIDTH-1:0] dout_a_q, dout_b_q;
  logic                  dout_valid_q;
  logic                  ovf_a_q, ovf_b_q;

  logic pop;
  logic full_a, full_b;
  logic wr_a, wr_b;
  logic drop_a, drop_b;

  // A pop frees a slot on the same edge, so a full lane can still accept a write.
  always_comb begin
    pop     = (cnt_a_q != '0) && (cnt_b_q != '0);
    full_a  = (cnt_a_q == FULL_CNT);
    full_b  = (cnt_b_q == FULL_CNT);
    wr_a    = din_a_valid && (!full_a || pop);
    wr_b    = din_b_valid && (!full_b || pop);
    drop_a  = din_a_valid && full_a && !pop;
    drop_b  = din_b_valid && full_b && !pop;
    cnt_a_d = cnt_a_q + CW'(wr_a) - CW'(pop);
    cnt_b_d = cnt_b_q + CW'(wr_b) - CW'(pop);
    skew_d  = SW'(cnt_a_d) - SW'(cnt_b_d);
  end

  // Storage carries no reset; pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (!clear && wr_a) mem_a_q[wr_a_q] <= din_a;
    if (!clear && wr_b) mem_b_q[wr_b_q] <= din_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_a_q       <= '0;
      rd_a_q       <= '0;
      wr_b_q       <= '0;
      rd_b_q       <= '0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      skew_q       <= '0;
      dout_a_q     <= '0;
      dout_b_q     <= '0;
      dout_valid_q <= 1'b0;
      ovf_a_q      <= 1'b0;
      ovf_b_q      <= 1'b0;
    end else if (clear) begin
      wr_a_q       <= '0;
      rd_a_q       <= '0;
      wr_b_q       <= '0;
      rd_b_q       <= '0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      skew_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_a_q      <= 1'b0;
      ovf_b_q      <= 1'b0;
    end else begin
      if (wr_a) wr_a_q <= wr_a_q + AW'(1);
      if (wr_b) wr_b_q <= wr_b_q + AW'(1);
      if (pop) begin
        rd_a_q   <= rd_a_q + AW'(1);
        rd_b_q   <= rd_b_q + AW'(1);
        dout_a_q <= mem_a_q[rd_a_q];
        dout_b_q <= mem_b_q[rd_b_q];
      end
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
      skew_q       <= skew_d;
      dout_valid_q <= pop;
      if (drop_a) ovf_a_q <= 1'b1;
      if (drop_b) ovf_b_q <= 1'b1;
    end
  end

  assign dout_a     = dout_a_q;
  assign dout_b     = dout_b_q;
  assign dout_valid = dout_valid_q;
  assign skew       = skew_q;
  assign ovf_a      = ovf_a_q;
  assign ovf_b      = ovf_b_q;

endmodule

// File: tb/tb_stream_align.sv
// Directed and randomized checks of stream_align: a depth-16 instance for the
// directed sequences and a depth-4 instance against a per-lane queue model.
module tb_stream_align;

  localparam int DW  = 8;
  localparam int D   = 16;
  localparam int SW  = $clog2(D) + 2;
  localparam int D4  = 4;
  localparam int SW4 = $clog2(D4) + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          clear;
  logic [DW-1:0] din_a, din_b;
  logic          din_a_valid, din_b_valid;
  logic [DW-1:0] dout_a, dout_b;
  logic          dout_valid;
  logic [SW-1:0] skew;
  logic          ovf_a, ovf_b;

  logic           r_clear;
  logic [DW-1:0]  r_din_a, r_din_b;
  logic           r_din_a_valid, r_din_b_valid;
  logic [DW-1:0]  r_dout_a, r_dout_b;
  logic           r_dout_valid;
  logic [SW4-1:0] r_skew;
  logic           r_ovf_a, r_ovf_b;

  stream_align #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .din_a(din_a), .din_a_valid(din_a_valid),
    .din_b(din_b), .din_b_valid(din_b_valid),
    .dout_a(dout_a), .dout_b(dout_b), .dout_valid(dout_valid),
    .skew(skew), .ovf_a(ovf_a), .ovf_b(ovf_b)
  );

  stream_align #(.DATA_WIDTH(DW), .FIFO_DEPTH(D4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clear(r_clear),
    .din_a(r_din_a), .din_a_valid(r_din_a_valid),
    .din_b(r_din_b), .din_b_valid(r_din_b_valid),
    .dout_a(r_dout_a), .dout_b(r_dout_b), .dout_valid(r_dout_valid),
    .skew(r_skew), .ovf_a(r_ovf_a), .ovf_b(r_ovf_b)
  );

  typedef struct {
    logic          va;
    logic [DW-1:0] a;
    logic          vb;
    logic [DW-1:0] b;
    logic          edv;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    int            esk;
  } vec_t;

  vec_t tv[10];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic int sk16();
    int s;
    s = $signed(skew);
    return s;
  endfunction

  function automatic int sk4();
    int s;
    s = $signed(r_skew);
    return s;
  endfunction

  task automatic cyc(input logic va, input logic [DW-1:0] a, input logic vb, input logic [DW-1:0] b);
    din_a_valid = va;
    din_a       = a;
    din_b_valid = vb;
    din_b       = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [DW-1:0] got_a[$];
    logic [DW-1:0] got_b[$];
    int            npairs;
    logic          m_pop, m_oa, m_ob;
    logic [DW-1:0] m_ea, m_eb;
    int            pa, pb;

    rst_n = 1'b0;
    clear = 1'b0;
    din_a = '0; din_b = '0; din_a_valid = 1'b0; din_b_valid = 1'b0;
    r_clear = 1'b0;
    r_din_a = '0; r_din_b = '0; r_din_a_valid = 1'b0; r_din_b_valid = 1'b0;

    // basic alignment vector table: A early, B three edges late
    tv[0] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1};
    tv[1] = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 2};
    tv[2] = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 3};
    tv[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 3};
    tv[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 3};
    tv[5] = '{1'b0, 8'h00, 1'b1, 8'h91, 1'b0, 8'h00, 8'h00, 2};
    tv[6] = '{1'b0, 8'h00, 1'b1, 8'hA2, 1'b1, 8'h11, 8'h91, 1};
    tv[7] = '{1'b0, 8'h00, 1'b1, 8'hB3, 1'b1, 8'h22, 8'hA2, 0};
    tv[8] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h33, 8'hB3, 0};
    tv[9] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h33, 8'hB3, 0};

    #7;
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout_a", 32'(dout_a), 32'd0);
    chk("rst_dout_b", 32'(dout_b), 32'd0);
    chk("rst_skew", 32'(sk16()), 32'd0);
    chk("rst_ovf", 32'({ovf_a, ovf_b}), 32'd0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      cyc(tv[i].va, tv[i].a, tv[i].vb, tv[i].b);
      chk($sformatf("tbl%0d_dv", i), 32'(dout_valid), 32'(tv[i].edv));
      chk($sformatf("tbl%0d_a", i), 32'(dout_a), 32'(tv[i].ea));
      chk($sformatf("tbl%0d_b", i), 32'(dout_b), 32'(tv[i].eb));
      chk($sformatf("tbl%0d_skew", i), 32'(sk16()), 32'(tv[i].esk));
    end

    // sustained throughput: counter on A, counter+7 on B
    npairs = 0;
    for (int i = 0; i < 102; i++) begin
      cyc(i < 100, DW'(i), i < 100, DW'(i + 7));
      chk("thr_dv", 32'(dout_valid), 32'(i >= 1 && i <= 100));
      chk("thr_skew", 32'(sk16()), 32'd0);
      if (dout_valid) begin
        npairs++;
        chk("thr_a", 32'(dout_a), 32'(DW'(i - 1)));
        chk("thr_diff", 32'(DW'(dout_b - dout_a)), 32'd7);
      end
    end
    chk("thr_pairs", 32'(npairs), 32'd100);

    // overflow on lane A with B idle
    for (int i = 0; i < 18; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 8'h00);
      chk("ovf_dv", 32'(dout_valid), 32'd0);
      if (i == 15) chk("ovf_a_before", 32'(ovf_a), 32'd0);
      if (i >= 16) chk("ovf_a_set", 32'(ovf_a), 32'd1);
    end
    chk("ovf_skew_full", 32'(sk16()), 32'd16);
    got_a.delete(); got_b.delete();
    for (int j = 0; j < 18; j++) begin
      cyc(1'b0, 8'h00, j < 16, DW'(8'h40 + j));
      if (dout_valid) begin
        got_a.push_back(dout_a);
        got_b.push_back(dout_b);
      end
    end
    chk("ovf_npairs", 32'(got_a.size()), 32'd16);
    for (int k = 0; k < got_a.size() && k < 16; k++) begin
      chk($sformatf("ovf_pair%0d_a", k), 32'(got_a[k]), 32'(k));
      chk($sformatf("ovf_pair%0d_b", k), 32'(got_b[k]), 32'(8'h40 + k));
    end
    chk("ovf_a_sticky", 32'(ovf_a), 32'd1);
    chk("ovf_b_clean", 32'(ovf_b), 32'd0);
    chk("ovf_skew_end", 32'(sk16()), 32'd0);

    // clear with A five ahead and a pop pending
    for (int i = 0; i < 6; i++) cyc(1'b1, DW'(8'hA0 + i), 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 1'b1, 8'hB0);
    chk("clr_pre_skew", 32'(sk16()), 32'd5);
    clear = 1'b1;
    cyc(1'b1, 8'hEE, 1'b1, 8'hEE);
    clear = 1'b0;
    chk("clr_skew", 32'(sk16()), 32'd0);
    chk("clr_ovf", 32'({ovf_a, ovf_b}), 32'd0);
    chk("clr_dv", 32'(dout_valid), 32'd0);
    cyc(1'b1, 8'h5A, 1'b1, 8'hC3);
    chk("clr_fresh_dv0", 32'(dout_valid), 32'd0);
    chk("clr_fresh_skew", 32'(sk16()), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    chk("clr_fresh_dv1", 32'(dout_valid), 32'd1);
    chk("clr_fresh_a", 32'(dout_a), 32'h5A);
    chk("clr_fresh_b", 32'(dout_b), 32'hC3);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);

    // asynchronous reset mid-stream
    cyc(1'b1, 8'h01, 1'b0, 8'h00);
    cyc(1'b1, 8'h02, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(3 + i), 1'b1, DW'(8'h61 + i));
    chk("ar_pre_dv", 32'(dout_valid), 32'd1);
    chk("ar_pre_skew", 32'(sk16()), 32'd2);
    din_a_valid = 1'b0;
    din_b_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_dv", 32'(dout_valid), 32'd0);
    chk("ar_dout", 32'({dout_a, dout_b}), 32'd0);
    chk("ar_skew", 32'(sk16()), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1, DW'(8'h70 + i));
      chk("ar_bonly_dv", 32'(dout_valid), 32'd0);
    end
    chk("ar_bonly_skew", 32'(sk16()), -32'sd4);

    // randomized depth-4 run against per-lane queues
    qa.delete(); qb.delete();
    m_oa = 1'b0; m_ob = 1'b0;
    for (int i = 0; i < 300; i++) begin
      pa = (i < 100) ? 80 : (i < 200) ? 30 : 55;
      pb = (i < 100) ? 30 : (i < 200) ? 80 : 55;
      r_din_a_valid = ($urandom_range(99) < pa);
      r_din_b_valid = ($urandom_range(99) < pb);
      r_din_a = DW'($urandom);
      r_din_b = DW'($urandom);
      m_pop = (qa.size() > 0) && (qb.size() > 0);
      m_ea = '0; m_eb = '0;
      if (m_pop) begin
        m_ea = qa.pop_front();
        m_eb = qb.pop_front();
      end
      if (r_din_a_valid) begin
        if (qa.size() < D4) qa.push_back(r_din_a);
        else m_oa = 1'b1;
      end
      if (r_din_b_valid) begin
        if (qb.size() < D4) qb.push_back(r_din_b);
        else m_ob = 1'b1;
      end
      @(posedge clk); #1;
      chk("rnd_dv", 32'(r_dout_valid), 32'(m_pop));
      if (m_pop) begin
        chk("rnd_a", 32'(r_dout_a), 32'(m_ea));
        chk("rnd_b", 32'(r_dout_b), 32'(m_eb));
      end
      chk("rnd_ovf_a", 32'(r_ovf_a), 32'(m_oa));
      chk("rnd_ovf_b", 32'(r_ovf_b), 32'(m_ob));
      chk("rnd_skew", 32'(sk4()), 32'(qa.size() - qb.size()));
    end
    chk("rnd_saw_ovf", 32'({m_oa, m_ob}), 32'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
